// File: rtl/hydra_pkg.sv
// Shared types and sizing for the page arbiter slice.
package hydra_pkg;
  localparam int PORT_NUM   = 16;
  localparam int PAGE_WORDS = 8;

  typedef logic [2:0] prior_t;
  typedef logic [3:0] port_idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;
endpackage

// File: rtl/page_arbiter_rr_pick.sv
// Combinational round-robin first-set search: scans mask upward from ptr, wrapping.
module rr_pick
  import hydra_pkg::*;
#(
  parameter int N = hydra_pkg::PORT_NUM
) (
  input  logic [N-1:0] mask,
  input  port_idx_t    ptr,
  output logic         found,
  output port_idx_t    idx
);
  port_idx_t cand;

  // Walk from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = port_idx_t'((int'(ptr) + k) % N);
      if (mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/page_arbiter.sv
// Page burst arbiter for the shared SRAM write path; round-robin with back-to-back bursts.
// Defining PAGE_ARB_PRIORITY_EN restricts each arbitration to the highest-priority requesters.
module page_arbiter
  import hydra_pkg::*;
#(
  parameter int PORT_NUM   = hydra_pkg::PORT_NUM,
  parameter int PAGE_WORDS = hydra_pkg::PAGE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_NUM-1:0]   req,
  input  logic [3*PORT_NUM-1:0] req_prior,
  output logic [PORT_NUM-1:0]   gnt,
  output logic                  gnt_vld,
  output logic [3:0]            gnt_port,
  output logic [2:0]            word_cnt,
  output logic                  gnt_last
);
  arb_state_e          state_q;
  logic [PORT_NUM-1:0] gnt_q;
  logic                gnt_vld_q;
  logic                gnt_last_q;
  port_idx_t           gnt_port_q;
  port_idx_t           rr_ptr_q;
  logic [2:0]          word_cnt_q;

  logic [PORT_NUM-1:0] elig;
  logic                burst_end;
  port_idx_t           next_rr;
  port_idx_t           pick_ptr;
  logic                found;
  port_idx_t           win;

`ifdef PAGE_ARB_PRIORITY_EN
  prior_t max_p;
  always_comb begin
    max_p = '0;
    elig  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (req[i] && (req_prior[3*i +: 3] > max_p)) max_p = req_prior[3*i +: 3];
    end
    for (int i = 0; i < PORT_NUM; i++) begin
      elig[i] = req[i] && (req_prior[3*i +: 3] == max_p);
    end
  end
`else
  logic unused_prior;
  assign unused_prior = ^req_prior;
  assign elig         = req;
`endif

  // A burst ends on its last word or when the owner withdraws; both re-arbitrate at once.
  assign burst_end = (state_q == ST_BURST) && (gnt_last_q || !req[gnt_port_q]);
  assign next_rr   = (int'(gnt_port_q) == PORT_NUM - 1) ? '0 : gnt_port_q + 4'd1;
  assign pick_ptr  = burst_end ? next_rr : rr_ptr_q;

  rr_pick #(.N(PORT_NUM)) u_pick (
    .mask  (elig),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_last_q <= 1'b0;
      gnt_port_q <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      if (burst_end) rr_ptr_q <= next_rr;
      case (state_q)
        ST_BURST: begin
          if (!burst_end) begin
            word_cnt_q <= word_cnt_q + 3'd1;
            gnt_last_q <= ((word_cnt_q + 3'd1) == 3'(PAGE_WORDS - 1));
          end
        end
        default: ;
      endcase
      if ((state_q == ST_IDLE) || burst_end) begin
        if (found) begin
          state_q    <= ST_BURST;
          gnt_q      <= {{(PORT_NUM-1){1'b0}}, 1'b1} << win;
          gnt_vld_q  <= 1'b1;
          gnt_port_q <= win;
          word_cnt_q <= '0;
          gnt_last_q <= (PAGE_WORDS == 1);
        end else begin
          state_q    <= ST_IDLE;
          gnt_q      <= '0;
          gnt_vld_q  <= 1'b0;
          gnt_port_q <= '0;
          word_cnt_q <= '0;
          gnt_last_q <= 1'b0;
        end
      end
    end
  end

  assign gnt      = gnt_q;
  assign gnt_vld  = gnt_vld_q;
  assign gnt_port = gnt_port_q;
  assign word_cnt = word_cnt_q;
  assign gnt_last = gnt_last_q;
endmodule

// File: doc/page_arbiter.md
PAGE_ARBITER -- requirements
Module: page_arbiter

Interface
REQ-001 The parameter PORT_NUM SHALL default to 16 and set the number of ingress ports that compete for the shared SRAM write path.
REQ-002 The parameter PAGE_WORDS SHALL default to 8 and set the number of 16-bit words in one granted page burst.
REQ-003 The ports SHALL be, one per line:
- clk  input  1  sole clock, all state on posedge
- rst_n  input  1  asynchronous, active-low reset
- req  input  PORT_NUM  bit i high = port i holds a page ready to write
- req_prior  input  3*PORT_NUM  bits [3i+2:3i] = priority of port i's page, 7 highest
- gnt  output  PORT_NUM  one-hot grant, registered
- gnt_vld  output  1  a burst is in progress this cycle
- gnt_port  output  4  index of the granted port
- word_cnt  output  3  word index within the burst, 0..PAGE_WORDS-1
- gnt_last  output  1  this cycle carries the final word of the burst

Function
REQ-004 The block SHALL have two states: IDLE (gnt_vld=0) and BURST (gnt_vld=1).
REQ-005 In IDLE, if any req bit is high at a posedge, the block SHALL enter BURST on that edge with gnt_port=winner, gnt=1<<winner, word_cnt=0, giving one cycle of req-to-grant latency.
REQ-006 Winner selection SHALL search req starting at rr_ptr and proceeding upward modulo PORT_NUM, taking the first set bit.
REQ-007 In BURST, word_cnt SHALL increment by 1 per cycle, and gnt_last SHALL be high exactly in the cycle where word_cnt==PAGE_WORDS-1.
REQ-008 On the edge that ends the cycle where gnt_last=1, rr_ptr SHALL become (gnt_port+1) mod PORT_NUM.
REQ-009 On that same edge, arbitration SHALL be re-run with the updated rr_ptr, so that a new burst starts with no bubble cycle if any req is high; otherwise the block SHALL return to IDLE.
REQ-010 If req[gnt_port] is low during any BURST cycle, the burst SHALL abort: on the next edge the block SHALL act exactly as at gnt_last (REQ-008 and REQ-009), and gnt_last SHALL not be asserted for the aborted burst.
REQ-011 The req bits of non-granted ports SHALL NOT affect an ongoing burst.
REQ-012 A single port requesting continuously SHALL receive back-to-back bursts.
REQ-013 gnt SHALL be all-zero whenever gnt_vld=0, and gnt_port and word_cnt SHALL read 0 in IDLE.
REQ-014 All outputs SHALL be driven directly from registers.

Reset
REQ-015 Asserting rst_n low SHALL immediately force IDLE, gnt=0, gnt_vld=0, gnt_port=0, word_cnt=0, gnt_last=0 and rr_ptr=0, including in the middle of a burst.
REQ-016 The first posedge after rst_n deasserts SHALL arbitrate normally from rr_ptr=0.

Configuration
REQ-017 When the macro PAGE_ARB_PRIORITY_EN is defined, arbitration SHALL consider only requesters whose req_prior equals the maximum req_prior among active requesters, then apply the round-robin rule of REQ-006 to that subset.
REQ-018 When PAGE_ARB_PRIORITY_EN is undefined, req_prior SHALL be ignored and arbitration SHALL be pure round-robin.
REQ-019 The macro SHALL NOT change latency, burst length or the abort behaviour.

Structure
REQ-020 PORT_NUM, PAGE_WORDS and the typedefs prior_t (3 bits) and port_idx_t (4 bits) SHALL live in the shared package hydra_pkg.
REQ-021 Round-robin first-set search SHALL be a combinational sub-module rr_pick (inputs: mask, ptr; outputs: found, idx), instantiated once.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset, then req=0x0001 held: gnt=0x0001 one cycle later; word_cnt 0..7; gnt_last on word 7; next burst back-to-back to port 0 with no gap.
- req=0xFFFF held, macro off: bursts granted in order to ports 0,1,2,...,15,0, each 8 cycles, with no idle cycles.
- Port 3 granted and req[3] dropped at word_cnt=4, with req[9] high: gnt_vld stays high; gnt switches to port 9 on the next edge with word_cnt=0; gnt_last never fires for port 3; rr_ptr=4.
- Macro on, req=0x0006, req_prior[port1]=2, req_prior[port2]=5: port 2 granted first even though rr_ptr=0; then port 1.
- rst_n pulsed low at word_cnt=5: all outputs go to 0 asynchronously; after release with req=0x0100, gnt=0x0100 one cycle later.
- req=0 throughout: gnt_vld stays 0 and all outputs stay 0.
